// File: rtl/put_y_mat_row_if.sv
// rtl/put_y_mat_row_if.sv - start/sample-stream inputs and SRAM row-write outputs of put_y_mat_row
interface put_y_mat_row_if;
    logic        pYMR_start;
    logic [5:0]  pYMR_row_idx;
    logic        pYMR_in_valid;
    logic [15:0] pYMR_in_data;
    logic        pYMR_in_ready;
    logic [10:0] pYMR_row_addr;
    logic [15:0] pYMR_row_out;
    logic        pYMR_we;
    logic        pYMR_busy;
    logic        pYMR_done;
    logic        pYMR_err;

    modport master (
        output pYMR_start, pYMR_row_idx, pYMR_in_valid, pYMR_in_data,
        input  pYMR_in_ready, pYMR_row_addr, pYMR_row_out, pYMR_we,
               pYMR_busy, pYMR_done, pYMR_err
    );

    modport slave (
        input  pYMR_start, pYMR_row_idx, pYMR_in_valid, pYMR_in_data,
        output pYMR_in_ready, pYMR_row_addr, pYMR_row_out, pYMR_we,
               pYMR_busy, pYMR_done, pYMR_err
    );
endinterface

// File: rtl/put_y_mat_row.sv
// rtl/put_y_mat_row.sv - writes one Y-matrix row of x16-scaled, saturated samples into SRAM
module put_y_mat_row #(
    parameter int ROW_LEN = 32,
    parameter int ROWS    = 64
) (
    input logic             clock,
    input logic             reset,
    put_y_mat_row_if.slave  bus
);
    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    row_q;
    logic [CW-1:0] col_q;
    logic          we_q;
    logic          err_q;
    logic [10:0]   addr_q;
    logic [15:0]   data_q;

    logic          start_ok;
    logic          start_bad;
    logic          accept;
    logic          last_col;
    logic [19:0]   scaled;
    logic [15:0]   sat;
    logic          ready;
    logic          busy;
    logic          done;

    assign start_ok  = (state == IDLE) && bus.pYMR_start && ({1'b0, bus.pYMR_row_idx} <  7'(ROWS));
    assign start_bad = (state == IDLE) && bus.pYMR_start && ({1'b0, bus.pYMR_row_idx} >= 7'(ROWS));
    assign accept    = (state == WRITE) && bus.pYMR_in_valid;
    assign last_col  = (col_q == CW'(ROW_LEN - 1));

    // x16 fits exactly in 20 bits; it only fits 16 when the top five bits agree
    assign scaled = {bus.pYMR_in_data, 4'b0000};
    assign sat    = ((scaled[19:15] == 5'b00000) || (scaled[19:15] == 5'b11111)) ? scaled[15:0]
                  : (scaled[19] ? 16'h8000 : 16'h7FFF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = WRITE;
            WRITE:   if (accept && last_col) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            WRITE: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // addr/data only move on an accepted sample so they hold between writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_q  <= '0;
            col_q  <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q  <= accept;
            err_q <= start_bad;
            if (start_ok) begin
                row_q <= bus.pYMR_row_idx;
                col_q <= '0;
            end
            if (accept) begin
                col_q  <= col_q + 1'b1;
                addr_q <= 11'(row_q) * 11'(ROW_LEN) + 11'(col_q);
                data_q <= sat;
            end
        end
    end

    assign bus.pYMR_in_ready = ready;
    assign bus.pYMR_busy     = busy;
    assign bus.pYMR_done     = done;
    assign bus.pYMR_we       = we_q;
    assign bus.pYMR_err      = err_q;
    assign bus.pYMR_row_addr = addr_q;
    assign bus.pYMR_row_out  = data_q;
endmodule

// File: tb/tb_put_y_mat_row.sv
// tb/tb_put_y_mat_row.sv - randomized self-checking bench for put_y_mat_row (ROWS=64 and ROWS=48 instances)
module tb_put_y_mat_row;
    localparam int ROW_LEN = 32;
    localparam int LIMIT   = 600;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  idx   = '0;
    logic        valid = 1'b0;
    logic [15:0] data  = '0;

    int vecs = 0;
    int miss = 0;

    int          lim      [2] = '{64, 48};
    bit          m_in_row [2];
    bit          m_done   [2];
    bit          m_we     [2];
    bit          m_err    [2];
    int          m_cnt    [2];
    int          m_row    [2];
    int          m_starts [2];
    logic [10:0] m_addr   [2];
    logic [15:0] m_data   [2];
    logic [31:0] expv     [2];
    logic [31:0] obs      [2];

    always #5 clock = ~clock;

    put_y_mat_row_if bus0();
    put_y_mat_row_if bus1();

    assign bus0.pYMR_start    = start;
    assign bus0.pYMR_row_idx  = idx;
    assign bus0.pYMR_in_valid = valid;
    assign bus0.pYMR_in_data  = data;
    assign bus1.pYMR_start    = start;
    assign bus1.pYMR_row_idx  = idx;
    assign bus1.pYMR_in_valid = valid;
    assign bus1.pYMR_in_data  = data;

    put_y_mat_row #(.ROW_LEN(ROW_LEN), .ROWS(64)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    put_y_mat_row #(.ROW_LEN(ROW_LEN), .ROWS(48)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    function automatic logic [15:0] scale(input logic [15:0] d);
        int v;
        v = int'($signed(d)) * 16;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_in_row[k] = 0; m_done[k] = 0; m_we[k] = 0; m_err[k] = 0;
            m_cnt[k] = 0; m_row[k] = 0; m_addr[k] = '0; m_data[k] = '0; expv[k] = '0;
        end
    endtask

    task automatic sample();
        obs[0] = {bus0.pYMR_in_ready, bus0.pYMR_we, bus0.pYMR_done, bus0.pYMR_busy,
                  bus0.pYMR_err, bus0.pYMR_row_addr, bus0.pYMR_row_out};
        obs[1] = {bus1.pYMR_in_ready, bus1.pYMR_we, bus1.pYMR_done, bus1.pYMR_busy,
                  bus1.pYMR_err, bus1.pYMR_row_addr, bus1.pYMR_row_out};
    endtask

    // Expected vector: {ready, we, done, busy, err, addr[10:0], data[15:0]}
    task automatic cycle();
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit idle;
                bit acc;
                bit fin;
                idle     = !m_in_row[k] && !m_done[k];
                acc      = m_in_row[k] && valid;
                m_we[k]  = acc;
                m_err[k] = idle && start && (int'(idx) >= lim[k]);
                if (acc) begin
                    m_addr[k] = 11'(m_row[k] * ROW_LEN + m_cnt[k]);
                    m_data[k] = scale(data);
                    m_cnt[k]++;
                end
                fin       = acc && (m_cnt[k] == ROW_LEN);
                m_done[k] = fin;
                if (fin) m_in_row[k] = 0;
                if (idle && start && (int'(idx) < lim[k])) begin
                    m_in_row[k] = 1; m_cnt[k] = 0; m_row[k] = int'(idx); m_starts[k]++;
                end
                expv[k] = {m_in_row[k], m_we[k], m_done[k], m_in_row[k] | m_done[k],
                           m_err[k], m_addr[k], m_data[k]};
            end
        end
        #1;
        sample();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== 32'd0) begin
                    miss++;
                    $display("FAIL reset dut%0d outputs=%h required=00000000", k, obs[k]);
                end
            end
        end
        reset = 1'b1;
        cycle();
        for (int k = 0; k < 2; k++) begin
            vecs++;
            if (obs[k] !== expv[k]) begin
                miss++;
                $display("FAIL reset_release dut%0d got=%h required=%h", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_full_row();
        int c;
        int nw;
        nw = 0;
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = (m_starts[0] < 1) && !m_in_row[0];
            idx   = 6'd3;
            valid = !start;
            data  = 16'(m_cnt[0] + 1);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL full_row dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (bus0.pYMR_we) begin
                vecs++;
                if (bus0.pYMR_row_addr !== 11'(96 + nw) || bus0.pYMR_row_out !== 16'(16 * (nw + 1))
                    || bus0.pYMR_done !== (nw == 31)) begin
                    miss++;
                    $display("FAIL full_row_word %0d got addr=%0d data=%h done=%b required addr=%0d data=%h done=%b",
                             nw, bus0.pYMR_row_addr, bus0.pYMR_row_out, bus0.pYMR_done,
                             96 + nw, 16 * (nw + 1), nw == 31);
                end
                nw++;
            end
            if (m_starts[0] == 1 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT || nw != 32) begin
            miss++;
            $display("FAIL full_row_count got=%0d writes required=32 (cycles %0d)", nw, c);
        end
        start = 0; valid = 0;
    endtask

    task automatic test_saturation();
        logic [15:0] sin  [4] = '{16'h0123, 16'h0900, 16'hF000, 16'hF800};
        logic [15:0] sexp [4] = '{16'h1230, 16'h7FFF, 16'h8000, 16'h8000};
        int c;
        int nw;
        logic [5:0] r;
        nw = 0;
        r  = 6'($urandom_range(0, 47));
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = (m_starts[0] < 1) && !m_in_row[0];
            idx   = r;
            valid = !start;
            data  = (m_cnt[0] < 4) ? sin[m_cnt[0]] : 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL saturation dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (bus0.pYMR_we && nw < 4) begin
                vecs++;
                if (bus0.pYMR_row_out !== sexp[nw]) begin
                    miss++;
                    $display("FAIL saturation_word %0d got=%h required=%h", nw, bus0.pYMR_row_out, sexp[nw]);
                end
            end
            if (bus0.pYMR_we) nw++;
            if (m_starts[0] == 1 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT || nw != 32) begin
            miss++;
            $display("FAIL saturation_count got=%0d writes required=32", nw);
        end
        start = 0; valid = 0;
    endtask

    task automatic test_stalls();
        int c;
        int nw;
        logic [5:0] r;
        nw = 0;
        r  = 6'($urandom_range(0, 47));
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = (m_starts[0] < 1) && !m_in_row[0];
            idx   = r;
            valid = (c > 0) && ((c - 1) % 3 == 0);
            data  = 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL stalls dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (bus0.pYMR_we) begin
                vecs++;
                if (bus0.pYMR_row_addr !== 11'(int'(r) * ROW_LEN + nw)) begin
                    miss++;
                    $display("FAIL stalls_addr got=%0d required=%0d", bus0.pYMR_row_addr, int'(r) * ROW_LEN + nw);
                end
                nw++;
            end
            if (m_starts[0] == 1 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT || nw != 32) begin
            miss++;
            $display("FAIL stalls_count got=%0d writes required=32", nw);
        end
        start = 0; valid = 0;
    endtask

    task automatic test_illegal();
        int c;
        int w1;
        int e1;
        bit first_done;
        w1 = 0; e1 = 0; first_done = 1;
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = ((m_starts[0] < 2) && !m_in_row[0]) || (c == 10);
            idx   = (c == 10) ? 6'd55 : ((m_starts[0] == 0) ? 6'd63 : 6'd50);
            valid = 1'b1;
            data  = 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL illegal dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (bus1.pYMR_we)  w1++;
            if (bus1.pYMR_err) e1++;
            if (bus0.pYMR_done && first_done) begin
                first_done = 0;
                vecs++;
                if (bus0.pYMR_row_addr !== 11'd2047) begin
                    miss++;
                    $display("FAIL illegal_last_addr got=%0d required=2047", bus0.pYMR_row_addr);
                end
            end
            if (m_starts[0] == 2 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT || w1 != 0 || e1 < 2) begin
            miss++;
            $display("FAIL illegal_rows48 got writes=%0d errs=%0d required writes=0 errs>=2", w1, e1);
        end
        start = 0; valid = 0;
    endtask

    task automatic test_back_to_back();
        int c;
        int idle_cycles;
        logic [5:0] ra;
        logic [5:0] rb;
        idle_cycles = 0;
        ra = 6'($urandom_range(0, 47));
        rb = 6'($urandom_range(0, 47));
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = (m_starts[0] < 2) && !m_in_row[0];
            idx   = (m_starts[0] == 0) ? ra : rb;
            valid = ($urandom_range(0, 3) != 0);
            data  = 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL back_to_back dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (c > 0 && !bus0.pYMR_busy) idle_cycles++;
            if (m_starts[0] == 2 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT || idle_cycles != 2) begin
            miss++;
            $display("FAIL back_to_back_gap got=%0d idle cycles required=2 (one gap, one tail)", idle_cycles);
        end
        start = 0; valid = 0;
    endtask

    task automatic test_reset_mid_row();
        int c;
        int nw;
        logic [5:0] r;
        r = 6'($urandom_range(0, 47));
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = (m_starts[0] < 1) && !m_in_row[0];
            idx   = r;
            valid = !start;
            data  = 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL mid_row dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (m_cnt[0] == 10) break;
        end
        #2 reset = 1'b0;
        #1 sample();
        model_clear();
        for (int k = 0; k < 2; k++) begin
            vecs++;
            if (obs[k] !== 32'd0) begin
                miss++;
                $display("FAIL mid_row_async dut%0d outputs=%h required=00000000", k, obs[k]);
            end
        end
        start = 0; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL mid_row_held dut%0d got=%h required=%h", k, obs[k], expv[k]);
                end
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL mid_row_after dut%0d got=%h required=%h", k, obs[k], expv[k]);
                end
            end
        end
        nw = 0;
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT; c++) begin
            start = (m_starts[0] < 1) && !m_in_row[0];
            idx   = 6'd0;
            valid = !start;
            data  = 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL mid_row_restart dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (bus0.pYMR_we) begin
                vecs++;
                if (bus0.pYMR_row_addr !== 11'(nw)) begin
                    miss++;
                    $display("FAIL mid_row_addr got=%0d required=%0d", bus0.pYMR_row_addr, nw);
                end
                nw++;
            end
            if (m_starts[0] == 1 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT || nw != 32) begin
            miss++;
            $display("FAIL mid_row_count got=%0d writes required=32", nw);
        end
        start = 0; valid = 0;
    endtask

    task automatic test_random_rows();
        int c;
        m_starts = '{0, 0};
        for (c = 0; c < LIMIT * 2; c++) begin
            start = ((m_starts[0] < 3) && !m_in_row[0]) || ($urandom_range(0, 15) == 0);
            idx   = 6'($urandom_range(0, 63));
            valid = ($urandom_range(0, 2) != 0);
            data  = 16'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (obs[k] !== expv[k]) begin
                    miss++;
                    $display("FAIL random dut%0d cycle %0d got=%h required=%h", k, c, obs[k], expv[k]);
                end
            end
            if (m_starts[0] == 3 && !m_in_row[0] && !m_done[0]) break;
        end
        vecs++;
        if (c == LIMIT * 2) begin
            miss++;
            $display("FAIL random_timeout got=%0d rows started required=3 finished", m_starts[0]);
        end
        start = 0; valid = 0;
    endtask

    initial begin
        model_clear();
        m_starts = '{0, 0};
        test_reset();
        test_full_row();
        test_saturation();
        test_stalls();
        test_illegal();
        test_back_to_back();
        test_reset_mid_row();
        test_random_rows();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
